// File: rtl/ram_pingpong_pkg.sv
// Shared types for the ping-pong bank controller.
// Bank lifecycle and drain states.
package ram_pingpong_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FULL  = 2'd1,
        BANK_DRAIN = 2'd2
    } bank_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    localparam logic BANK1 = 1'b0;
    localparam logic BANK2 = 1'b1;

endpackage

// File: rtl/ram_drain_fsm.sv
// Drain side of the ping-pong controller: walks the closed bank
// with a valid/ready handshake, alternating banks in close order.
module ram_drain_fsm
    import ram_pingpong_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        full_i,
    input  logic [ADDR_W:0]   len0_i,
    input  logic [ADDR_W:0]   len1_i,
    input  logic              rd_ready_i,
    output logic              take_o,
    output logic              free_o,
    output logic              rd_bank_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic              ram_rd_sel_o,
    output logic [ADDR_W-1:0] ram_rd_addr_o
);

    rd_state_t         state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   cur_len;
    logic              is_last;

    assign cur_len = rd_bank_q ? len1_i : len0_i;
    assign is_last = ({1'b0, rd_addr_q} == cur_len - (ADDR_W+1)'(1));

    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_addr_d  = rd_addr_q;
        take_o     = 1'b0;
        free_o     = 1'b0;
        rd_valid_o = 1'b0;
        rd_last_o  = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (full_i[rd_bank_q]) begin
                    take_o    = 1'b1;
                    state_d   = RD_DRAIN;
                    rd_addr_d = '0;
                end
            end
            RD_DRAIN: begin
                rd_valid_o = 1'b1;
                rd_last_o  = is_last;
                if (rd_ready_i) begin
                    if (is_last) begin
                        // last word hands the bank back and flips to its twin
                        free_o    = 1'b1;
                        state_d   = RD_IDLE;
                        rd_bank_d = ~rd_bank_q;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            rd_bank_q <= BANK1;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign rd_bank_o     = rd_bank_q;
    assign ram_rd_sel_o  = rd_valid_o & rd_bank_q;
    assign ram_rd_addr_o = rd_addr_q;

endmodule

// File: rtl/ram_pingpong_ctrl.sv
// Ping-pong write steering for two RAM banks with a drain port.
// Define RAM_SEL_REG_EN to register the RAM write-side outputs.
module ram_pingpong_ctrl
    import ram_pingpong_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_strobe,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic              wr_ready,
    output logic              ram_sel_1,
    output logic              ram_sel_2,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_sel,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic [1:0]        bank_full,
    output logic              overflow
);

    localparam int DEPTH = 2**ADDR_W;

    bank_state_t       state_q [2];
    bank_state_t       state_d [2];
    logic [ADDR_W:0]   len_q   [2];
    logic [ADDR_W:0]   len_d   [2];
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              overflow_q, overflow_d;

    logic              accept, at_top, close;
    logic [ADDR_W:0]   close_len;
    logic              take, free, rd_bank;
    logic              sel1_c, sel2_c;

    assign wr_ready  = (state_q[wr_bank_q] == BANK_EMPTY);
    assign accept    = write_strobe & wr_ready;
    assign at_top    = (wr_cnt_q == ADDR_W'(DEPTH-1));
    assign close     = (accept & at_top) |
                       (flush & wr_ready & (accept | (wr_cnt_q != '0)));
    assign close_len = {1'b0, wr_cnt_q} + {{ADDR_W{1'b0}}, accept};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            len_d[b]   = len_q[b];
        end
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        overflow_d = overflow_q | (write_strobe & ~wr_ready);
        if (close) begin
            state_d[wr_bank_q] = BANK_FULL;
            len_d[wr_bank_q]   = close_len;
            wr_bank_d          = ~wr_bank_q;
            wr_cnt_d           = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
        // take/free only touch FULL/DRAIN banks, never the one being closed
        if (take) state_d[rd_bank] = BANK_DRAIN;
        if (free) state_d[rd_bank] = BANK_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= BANK_EMPTY;
                len_q[b]   <= '0;
            end
            wr_bank_q  <= BANK1;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                len_q[b]   <= len_d[b];
            end
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign bank_full = {state_q[1] != BANK_EMPTY, state_q[0] != BANK_EMPTY};
    assign sel1_c    = accept & (wr_bank_q == BANK1);
    assign sel2_c    = accept & (wr_bank_q == BANK2);

`ifdef RAM_SEL_REG_EN
    logic              sel1_q, sel2_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel1_q  <= 1'b0;
            sel2_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            sel1_q  <= sel1_c;
            sel2_q  <= sel2_c;
            waddr_q <= wr_cnt_q;
            wdata_q <= wr_data;
        end
    end

    assign ram_sel_1   = sel1_q;
    assign ram_sel_2   = sel2_q;
    assign ram_wr_addr = waddr_q;
    assign ram_wr_data = wdata_q;
`else
    assign ram_sel_1   = sel1_c;
    assign ram_sel_2   = sel2_c;
    assign ram_wr_addr = wr_cnt_q;
    assign ram_wr_data = wr_data;
`endif

    ram_drain_fsm #(
        .ADDR_W (ADDR_W)
    ) u_drain (
        .clk           (clk),
        .rst_n         (rst_n),
        .full_i        ({state_q[1] == BANK_FULL, state_q[0] == BANK_FULL}),
        .len0_i        (len_q[0]),
        .len1_i        (len_q[1]),
        .rd_ready_i    (rd_ready),
        .take_o        (take),
        .free_o        (free),
        .rd_bank_o     (rd_bank),
        .rd_valid_o    (rd_valid),
        .rd_last_o     (rd_last),
        .ram_rd_sel_o  (ram_rd_sel),
        .ram_rd_addr_o (ram_rd_addr)
    );

endmodule

// File: tb/tb_ram_pingpong_ctrl.sv
// Directed self-checking bench for ram_pingpong_ctrl (DEPTH = 16).
module tb_ram_pingpong_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       wr_ready;
    logic       ram_sel_1;
    logic       ram_sel_2;
    logic [3:0] ram_wr_addr;
    logic [7:0] ram_wr_data;
    logic       ram_rd_sel;
    logic [3:0] ram_rd_addr;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       rd_last;
    logic [1:0] bank_full;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_pingpong_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_strobe (write_strobe),
        .wr_data      (wr_data),
        .flush        (flush),
        .wr_ready     (wr_ready),
        .ram_sel_1    (ram_sel_1),
        .ram_sel_2    (ram_sel_2),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_sel   (ram_rd_sel),
        .ram_rd_addr  (ram_rd_addr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .bank_full    (bank_full),
        .overflow     (overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        write_strobe = 1'b0;
        wr_data      = 8'h00;
        flush        = 1'b0;
        rd_ready     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            write_strobe = 1'b1;
            wr_data      = 8'(i);
            tick();
        end
        write_strobe = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #2;
        n_tests++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        n_tests++;
        if ({ram_sel_1, ram_sel_2, rd_valid, rd_last, ram_rd_sel, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b%b%b%b%b%b want 000000", ram_sel_1,
                     ram_sel_2, rd_valid, rd_last, ram_rd_sel, overflow);
        end
        n_tests++;
        if ({bank_full, ram_wr_addr, ram_rd_addr, ram_wr_data} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_buses: full=%b wa=%0h ra=%0h wd=%0h want 0",
                     bank_full, ram_wr_addr, ram_rd_addr, ram_wr_data);
        end
    endtask

    task automatic test_fill;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_strobe = 1'b1;
            wr_data      = 8'(i);
            #2;
            n_tests++;
            if ({ram_sel_1, ram_sel_2, ram_wr_addr, ram_wr_data} !== {2'b10, 4'(i), 8'(i)}) begin
                n_fail++;
                $display("FAIL fill_wr[%0d]: sel=%b%b a=%0h d=%0h want sel=10 a=d=%0h",
                         i, ram_sel_1, ram_sel_2, ram_wr_addr, ram_wr_data, i);
            end
            tick();
        end
        write_strobe = 1'b0;
        #2;
        n_tests++;
        if ({bank_full, rd_valid, wr_ready} !== 4'b0101) begin
            n_fail++;
            $display("FAIL fill_close: full=%b valid=%b ready=%b want 01 0 1",
                     bank_full, rd_valid, wr_ready);
        end
        rd_ready = 1'b1;
        tick();
        for (int j = 0; j < 16; j++) begin
            #2;
            n_tests++;
            if ({rd_valid, ram_rd_sel, ram_rd_addr, rd_last} !== {2'b10, 4'(j), j == 15}) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: v=%b sel=%b a=%0h last=%b want 1 0 %0h %b",
                         j, rd_valid, ram_rd_sel, ram_rd_addr, rd_last, j, j == 15);
            end
            tick();
        end
        #2;
        n_tests++;
        if ({bank_full, rd_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL fill_done: full=%b valid=%b want 00 0", bank_full, rd_valid);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_flush;
        do_reset();
        push(5);
        write_strobe = 1'b1;
        flush        = 1'b1;
        wr_data      = 8'h55;
        #2;
        n_tests++;
        if ({ram_sel_1, ram_wr_addr} !== 5'b1_0101) begin
            n_fail++;
            $display("FAIL flush_6th: sel1=%b a=%0h want 1 5", ram_sel_1, ram_wr_addr);
        end
        tick();
        flush = 1'b0;
        #2;
        n_tests++;
        if ({ram_sel_1, ram_sel_2, ram_wr_addr, bank_full} !== 8'b01_0000_01) begin
            n_fail++;
            $display("FAIL flush_bank2: sel=%b%b a=%0h full=%b want 01 0 01",
                     ram_sel_1, ram_sel_2, ram_wr_addr, bank_full);
        end
        tick();
        write_strobe = 1'b0;
        rd_ready     = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #2;
            n_tests++;
            if ({rd_valid, ram_rd_addr, rd_last} !== {1'b1, 4'(j), j == 5}) begin
                n_fail++;
                $display("FAIL flush_drain[%0d]: v=%b a=%0h last=%b want 1 %0h %b",
                         j, rd_valid, ram_rd_addr, rd_last, j, j == 5);
            end
            tick();
        end
        #2;
        n_tests++;
        if ({rd_valid, bank_full} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_done: v=%b full=%b want 0 00", rd_valid, bank_full);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            write_strobe = 1'b1;
            wr_data      = 8'(i);
            #2;
            n_tests++;
            if ({wr_ready, ram_sel_1, ram_sel_2, ram_wr_addr} !== {1'b1, i < 16, i >= 16, 4'(i)}) begin
                n_fail++;
                $display("FAIL ovf_wr[%0d]: rdy=%b sel=%b%b a=%0h", i, wr_ready,
                         ram_sel_1, ram_sel_2, ram_wr_addr);
            end
            tick();
        end
        #2;
        n_tests++;
        if ({wr_ready, ram_sel_1, ram_sel_2, bank_full, overflow} !== 6'b000110) begin
            n_fail++;
            $display("FAIL ovf_33rd: rdy=%b sel=%b%b full=%b ovf=%b want 0 00 11 0",
                     wr_ready, ram_sel_1, ram_sel_2, bank_full, overflow);
        end
        tick();
        write_strobe = 1'b0;
        tick();
        #2;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        // drain bank 1 and strobe in the freeing cycle
        rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            write_strobe = (j == 15);
            #2;
            n_tests++;
            if ({rd_valid, ram_rd_addr, wr_ready, ram_sel_1} !== {1'b1, 4'(j), 2'b00}) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: v=%b a=%0h rdy=%b sel1=%b", j,
                         rd_valid, ram_rd_addr, wr_ready, ram_sel_1);
            end
            tick();
        end
        write_strobe = 1'b0;
        rd_ready     = 1'b0;
        #2;
        n_tests++;
        if ({wr_ready, bank_full, rd_valid, overflow} !== 5'b1_10_0_1) begin
            n_fail++;
            $display("FAIL ovf_freed: rdy=%b full=%b v=%b ovf=%b want 1 10 0 1",
                     wr_ready, bank_full, rd_valid, overflow);
        end
    endtask

    task automatic test_backpressure;
        int exp_addr;
        int cyc;
        do_reset();
        push(16);
        tick();
        exp_addr = 0;
        cyc      = 0;
        while (exp_addr < 16 && cyc < 40) begin
            rd_ready = cyc[0];
            #2;
            n_tests++;
            if ({rd_valid, ram_rd_addr, rd_last} !== {1'b1, 4'(exp_addr), exp_addr == 15}) begin
                n_fail++;
                $display("FAIL bp[%0d]: v=%b a=%0h last=%b want 1 %0h", cyc,
                         rd_valid, ram_rd_addr, rd_last, exp_addr);
            end
            if (rd_ready) exp_addr++;
            cyc++;
            tick();
        end
        rd_ready = 1'b0;
        #2;
        n_tests++;
        if (exp_addr != 16 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: words=%0d v=%b want 16 0", exp_addr, rd_valid);
        end
    endtask

    task automatic test_reset_mid_drain;
        bit found;
        do_reset();
        push(33);
        rd_ready = 1'b1;
        found    = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            #2;
            if (rd_valid === 1'b1 && ram_rd_addr === 4'd7) found = 1'b1;
            else tick();
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rmd_reach: addr 7 not seen, a=%0h want 7", ram_rd_addr);
        end
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        #2;
        n_tests++;
        if ({rd_valid, bank_full, wr_ready, overflow} !== 5'b0_00_1_0) begin
            n_fail++;
            $display("FAIL rmd_state: v=%b full=%b rdy=%b ovf=%b want 0 00 1 0",
                     rd_valid, bank_full, wr_ready, overflow);
        end
        write_strobe = 1'b1;
        #2;
        n_tests++;
        if ({ram_sel_1, ram_sel_2, ram_wr_addr} !== 6'b10_0000) begin
            n_fail++;
            $display("FAIL rmd_write: sel=%b%b a=%0h want 10 0", ram_sel_1,
                     ram_sel_2, ram_wr_addr);
        end
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic test_flush_empty;
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        #2;
        n_tests++;
        if ({bank_full, rd_valid, wr_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL fe_state: full=%b v=%b rdy=%b want 00 0 1",
                     bank_full, rd_valid, wr_ready);
        end
        write_strobe = 1'b1;
        #2;
        n_tests++;
        if ({ram_sel_1, ram_sel_2, ram_wr_addr} !== 6'b10_0000) begin
            n_fail++;
            $display("FAIL fe_write: sel=%b%b a=%0h want 10 0", ram_sel_1,
                     ram_sel_2, ram_wr_addr);
        end
        tick();
        write_strobe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_flush();
        test_overflow();
        test_backpressure();
        test_reset_mid_drain();
        test_flush_empty();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
